// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin arbiter that gives NREQ requesters burst access
// to a shared 8-bit bidirectional pad bus. It inserts one turnaround cycle
// whenever the bus direction flips between bursts.
module uio_bus_arbiter #(
    parameter int NREQ  = 4,   // number of requesters, 2..8
    parameter int BURST = 4    // beats per grant, 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   wr,
    input  logic [8*NREQ-1:0] wdata,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic [NREQ-1:0]   gnt,
    output logic              beat,
    output logic [7:0]        rdata,
    output logic              rvalid
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 4;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [PW-1:0]     win_q;
    logic [PW-1:0]     ptr_q;
    logic              dir_q;
    logic              last_dir_q;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        rdata_q;
    logic              rvalid_q;

    // Per-requester write bytes as an array so the winner can be selected by index.
    logic [7:0] wbyte [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_wbyte
            assign wbyte[gi] = wdata[8*gi +: 8];
        end
    endgenerate

    // Round-robin search: the lowest offset after ptr wins. The loop runs from the
    // farthest offset down, so the nearest requester is assigned last and takes priority.
    logic [PW-1:0]   pick_d;
    logic            pick_vld;
    logic [NREQ-1:0] gnt_pick;

    always_comb begin
        pick_vld = 1'b0;
        pick_d   = ptr_q;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[PW'((int'(ptr_q) + k) % NREQ)]) begin
                pick_vld = 1'b1;
                pick_d   = PW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign gnt_pick = NREQ'(1) << pick_d;

    // Beat qualification depends on the current req/ena. This lets an abort or a
    // pause silence the pads in the same cycle, without waiting for a register stage.
    logic aborting;
    logic running;
    logic finishing;

    assign aborting  = (state_q != IDLE) && !req[win_q];
    assign running   = (state_q == XFER) && ena && req[win_q];
    assign finishing = aborting || (running && (cnt_q == LAST_BEAT));

    assign beat    = running;
    assign uio_oe  = (running && dir_q) ? 8'hFF : 8'h00;
    assign uio_out = (running && dir_q) ? wbyte[win_q] : 8'h00;
    assign gnt     = gnt_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;

    // Arbiter FSM, beat counter, round-robin pointer and read capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            win_q      <= '0;
            ptr_q      <= PW'(NREQ - 1);
            dir_q      <= 1'b0;
            last_dir_q <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= 8'h00;
            rvalid_q   <= 1'b0;
        end else begin
            rvalid_q <= running && !dir_q;
            if (running && !dir_q) begin
                rdata_q <= uio_in;
            end

            if (state_q == IDLE) begin
                if (ena && pick_vld) begin
                    gnt_q   <= gnt_pick;
                    win_q   <= pick_d;
                    dir_q   <= wr[pick_d];
                    cnt_q   <= '0;
                    state_q <= (wr[pick_d] != last_dir_q) ? TURN : XFER;
                end
            end else if (finishing) begin
                // A normal completion and an abort both retire the burst the same way.
                state_q    <= IDLE;
                gnt_q      <= '0;
                ptr_q      <= win_q;
                last_dir_q <= dir_q;
                cnt_q      <= '0;
            end else if (state_q == TURN) begin
                if (ena) begin
                    state_q <= XFER;
                end
            end else if (running) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Testbench for uio_bus_arbiter. Directed scenarios push the beats and read bytes
// they expect into queues; a monitor pops them as the DUT presents beats/rvalid.
module tb_uio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  wr = '0;
    logic [31:0] wdata = '0;
    logic [7:0]  uio_in = '0;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic [3:0]  gnt;
    logic        beat;
    logic [7:0]  rdata;
    logic        rvalid;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] oe;
        logic [7:0] out;
    } beat_t;

    beat_t      exp_beats [$];
    logic [7:0] exp_rd [$];
    beat_t      mon_e;
    logic [7:0] mon_r;
    logic [7:0] rd_bytes [4];
    logic [3:0] exp_g;

    int n_tests = 0;
    int n_fail  = 0;

    uio_bus_arbiter #(.NREQ(4), .BURST(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .req     (req),
        .wr      (wr),
        .wdata   (wdata),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .gnt     (gnt),
        .beat    (beat),
        .rdata   (rdata),
        .rvalid  (rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push_beats(input logic [3:0] g, input logic [7:0] oe,
                              input logic [7:0] out, input int n);
        beat_t b;
        b.g   = g;
        b.oe  = oe;
        b.out = out;
        for (int i = 0; i < n; i++) exp_beats.push_back(b);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_beats.size() != 0 || exp_rd.size() != 0); i++) begin
            nxt();
            @(negedge clk);
            #1;
        end
        check("queues_drained", 32'(exp_beats.size() + exp_rd.size()), 32'd0);
    endtask

    // Monitor: each beat and each rvalid pulse consumes one expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (beat === 1'b1) begin
                if (exp_beats.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got gnt=%b oe=%h out=%h, expected no beat",
                             gnt, uio_oe, uio_out);
                end else begin
                    mon_e = exp_beats.pop_front();
                    check("beat", 32'({gnt, uio_oe, uio_out}), 32'(mon_e));
                    $display("[TB] beat gnt=%b oe=%h out=%h", gnt, uio_oe, uio_out);
                end
            end else begin
                check("idle_pads", 32'({uio_oe, uio_out}), 32'd0);
            end
            if (rvalid === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rvalid: got rdata=%h, expected no rvalid", rdata);
                end else begin
                    mon_r = exp_rd.pop_front();
                    check("rdata", 32'(rdata), 32'(mon_r));
                    $display("[TB] read rdata=%h", rdata);
                end
            end
        end
    end

    // Stimulus: directed scenarios with hand-computed expectations.
    initial begin
        rd_bytes[0] = 8'h11;
        rd_bytes[1] = 8'h22;
        rd_bytes[2] = 8'h33;
        rd_bytes[3] = 8'h44;

        // Reset state
        smp();
        check("reset_state", 32'({gnt, uio_oe, uio_out, beat, rdata, rvalid}), 32'd0);

        // Write burst from requester 0 straight after reset: TURN, then 4 beats of A5
        nxt();
        rst = 1'b0; ena = 1'b1; req = 4'b0001; wr = 4'b0001; wdata = 32'hD4C3B2A5;
        push_beats(4'b0001, 8'hFF, 8'hA5, 4);
        smp();
        check("t1_idle_gnt", 32'(gnt), 32'd0);
        nxt(); smp();
        check("t1_turn", 32'({gnt, beat, uio_oe}), 32'({4'b0001, 1'b0, 8'h00}));
        repeat (4) begin nxt(); smp(); end
        nxt(); req = 4'b0000; smp();
        check("t1_end_gnt", 32'(gnt), 32'd0);
        drain();

        // All four reading: order 0,1,2,3,0, no TURN, one idle cycle between bursts
        nxt(); rst = 1'b1; req = 4'b0000;
        nxt(); rst = 1'b0;
        nxt(); req = 4'b1111; wr = 4'b0000; uio_in = 8'h5A;
        for (int g = 0; g < 5; g++) push_beats(4'b0001 << (g % 4), 8'h00, 8'h00, 4);
        for (int i = 0; i < 20; i++) exp_rd.push_back(8'h5A);
        for (int c = 0; c < 25; c++) begin
            if (c != 0) nxt();
            smp();
            exp_g = (c % 5 == 0) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
            check("t2_gnt", 32'(gnt), 32'(exp_g));
        end
        nxt(); req = 4'b0000; smp();
        drain();

        // Read burst from requester 1 with distinct bytes on each beat
        nxt(); req = 4'b0010; wr = 4'b0000; uio_in = 8'h00;
        push_beats(4'b0010, 8'h00, 8'h00, 4);
        for (int i = 0; i < 4; i++) exp_rd.push_back(rd_bytes[i]);
        smp();
        check("t3_idle", 32'({gnt, rvalid}), 32'd0);
        for (int b = 0; b < 4; b++) begin
            nxt(); uio_in = rd_bytes[b]; smp();
            check("t3_beat", 32'(beat), 32'd1);
        end
        nxt(); req = 4'b0000; smp();
        check("t3_last_rvalid", 32'({rvalid, rdata}), 32'({1'b1, 8'h44}));
        nxt(); smp();
        check("t3_rvalid_clear", 32'(rvalid), 32'd0);
        drain();

        // Write burst aborted after 2 beats; requester 1 then wins over requester 0
        nxt(); req = 4'b0001; wr = 4'b0001;
        push_beats(4'b0001, 8'hFF, 8'hA5, 2);
        push_beats(4'b0010, 8'hFF, 8'hB2, 4);
        smp();
        nxt(); smp();
        check("t4_turn", 32'({gnt, beat, uio_oe}), 32'({4'b0001, 1'b0, 8'h00}));
        repeat (2) begin nxt(); smp(); end
        nxt(); req = 4'b0000; smp();
        check("t4_abort", 32'({gnt, beat, uio_oe, uio_out}), 32'({4'b0001, 1'b0, 16'h0000}));
        nxt(); req = 4'b0011; wr = 4'b0011; smp();
        check("t4_gnt_clear", 32'(gnt), 32'd0);
        nxt(); smp();
        check("t4_rr_winner", 32'(gnt), 32'(4'b0010));
        repeat (3) begin nxt(); smp(); end
        nxt(); req = 4'b0000; smp();
        check("t4_end", 32'(gnt), 32'd0);
        drain();

        // Write burst paused by ena=0 for 3 cycles after 2 beats
        nxt(); req = 4'b0100; wr = 4'b0100;
        push_beats(4'b0100, 8'hFF, 8'hC3, 4);
        smp();
        repeat (2) begin nxt(); smp(); end
        for (int p = 0; p < 3; p++) begin
            nxt(); ena = 1'b0; smp();
            check("t5_pause", 32'({gnt, beat, uio_oe, uio_out}), 32'({4'b0100, 1'b0, 16'h0000}));
        end
        nxt(); ena = 1'b1; smp();
        nxt(); smp();
        nxt(); req = 4'b0000; smp();
        check("t5_end", 32'(gnt), 32'd0);
        drain();

        // Reset pulsed between edges mid-write; a fresh grant follows with a TURN
        nxt(); req = 4'b1000; wr = 4'b1000;
        push_beats(4'b1000, 8'hFF, 8'hD4, 2);
        smp();
        repeat (2) begin nxt(); smp(); end
        nxt();
        #1 rst = 1'b1;
        #1 check("t6_rst_async", 32'({gnt, beat, uio_oe, uio_out, rdata, rvalid}), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        push_beats(4'b1000, 8'hFF, 8'hD4, 4);
        nxt(); smp();
        check("t6_turn", 32'({gnt, beat, uio_oe}), 32'({4'b1000, 1'b0, 8'h00}));
        repeat (4) begin nxt(); smp(); end
        nxt(); req = 4'b0000; smp();
        check("t6_end", 32'(gnt), 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uio_bus_arbiter.md
UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4; it sets the number of requesters, range 2..8.
REQ-002 The block SHALL have parameter BURST, default 4; it sets the beats per grant, range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ena  input  1  design enable; low blocks new grants and pauses an active transfer.
REQ-006 req  input  NREQ  per-requester request, level-sensitive, held for the whole burst.
REQ-007 wr  input  NREQ  per-requester direction: 1 = drive bus (write), 0 = sample bus (read).
REQ-008 wdata  input  8*NREQ  per-requester write byte; requester i uses bits [8i+7:8i].
REQ-009 uio_in  input  8  bidirectional pad input path.
REQ-010 uio_out  output  8  bidirectional pad output path.
REQ-011 uio_oe  output  8  pad output enable; 1 = drive.
REQ-012 gnt  output  NREQ  one-hot grant; all zero when idle.
REQ-013 beat  output  1  high in each cycle in which a beat transfers.
REQ-014 rdata  output  8  registered read byte.
REQ-015 rvalid  output  1  one-cycle pulse that qualifies rdata.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, TURN and XFER.
REQ-017 In IDLE with ena=1 and req!=0, the block SHALL pick the winner round-robin, searching ptr+1, ptr+2, ... modulo NREQ.
REQ-018 On that pick, the block SHALL register gnt and the winner's wr into dir on the same edge.
REQ-019 From IDLE, the next state SHALL be TURN if dir differs from last_dir, otherwise XFER.
REQ-020 TURN SHALL last exactly one cycle with gnt held, uio_oe=8'h00 and beat=0, then go to XFER.
REQ-021 XFER write beat (dir=1): the block SHALL drive uio_out = wdata slice of the winner, uio_oe=8'hFF, beat=1.
REQ-022 XFER read beat (dir=0): the block SHALL drive uio_oe=8'h00 and beat=1, and on that edge capture uio_in into rdata; rvalid=1 in the following cycle only.
REQ-023 uio_out SHALL be 8'h00 in every cycle that is not a write beat.
REQ-024 The beat counter SHALL count 0..BURST-1; on the last beat the block SHALL go to IDLE, set ptr to the winner, set last_dir to dir, and clear gnt on the next edge.
REQ-025 After every burst there SHALL be at least one IDLE cycle; the earliest re-grant is the cycle after the return to IDLE.
REQ-026 Abort: if req[winner]=0 during TURN or XFER, that cycle SHALL have beat=0 and uio_oe=8'h00; the next state SHALL be IDLE, with ptr and last_dir updated as for normal completion.
REQ-027 Pause: ena=0 in TURN or XFER SHALL force beat=0 and uio_oe=8'h00 and hold the state and counter; the transfer resumes when ena=1.
REQ-028 Abort SHALL take priority over pause.
REQ-029 Changes to wr[winner] during a burst SHALL be ignored; dir is fixed at grant time.
REQ-030 Requests arriving during a burst SHALL be considered only in IDLE; no preemption.

Reset
REQ-031 While rst=1, the block SHALL hold these values, asynchronously and without a clock edge: state=IDLE, gnt=0, uio_out=8'h00, uio_oe=8'h00, beat=0, rdata=8'h00, rvalid=0, counter=0, ptr=NREQ-1 (requester 0 first), last_dir=0 (read).
REQ-032 On rst during a burst, the burst SHALL be discarded and not resumed after reset.

Verification
REQ-033 After reset, req=0001, wr=0001, wdata0=8'hA5 -> gnt=0001, then 1 TURN cycle with oe=00, then 4 cycles with uio_out=A5, oe=FF, beat=1, then gnt=0.
REQ-034 req=1111 held with wr=0000 -> grant order 0,1,2,3,0; no TURN cycles; 1 idle cycle between bursts.
REQ-035 req=0010 with wr=0, uio_in=11,22,33,44 on the beats -> rdata=11,22,33,44, each with rvalid one cycle after its beat.
REQ-036 A write burst with req dropped after 2 beats -> exactly 2 beats, gnt=0 next cycle; the next request from requester 1 wins ahead of requester 0.
REQ-037 ena=0 for 3 cycles mid-write-burst -> beat=0 and oe=00 during the pause, total beats still 4.
REQ-038 rst pulsed between clock edges mid-write -> uio_oe=00 and gnt=0 immediately; after release with req held, the block starts a new grant with a TURN cycle.
